// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 2-flop synchroniser, 3-sample majority bit decision,
// byte and framing-error strobes, and a retriggerable activity indicator.
package midi_uart_rx_pkg;
    typedef logic [7:0] midi_byte_t;
endpackage

module midi_uart_rx
    import midi_uart_rx_pkg::*;
#(
    parameter int CLK_HZ   = 12_288_000,
    parameter int BAUD     = 31_250,
    parameter int ACT_CLKS = 1_228_800
) (
    input  logic       i_clk_aud,
    input  logic       i_aud_rst,
    input  logic       i_midi_rx,
    output logic       o_byte_valid,
    output midi_byte_t o_midi_byte,
    output logic       o_frame_err,
    output logic       o_activity
);
    localparam int BIT_CLKS = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF     = BIT_CLKS / 2;
    localparam int CNT_W    = $clog2(BIT_CLKS);
    localparam int ACT_W    = (ACT_CLKS > 1) ? $clog2(ACT_CLKS) : 1;

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
    localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_CLKS - 1);

    if (BIT_CLKS < 8) begin : g_bit_clks_check
        $error("midi_uart_rx: BIT_CLKS must be at least 8");
    end

    typedef enum logic [2:0] {ST_BREAK, ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t           state;
    logic             sync_1;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [1:0]       samp;
    logic [7:0]       shift;
    logic [ACT_W-1:0] act_cnt;
    logic             maj;
    logic             dec;
    logic             last;

    always_ff @(posedge i_clk_aud or posedge i_aud_rst) begin
        if (i_aud_rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= i_midi_rx;
            rx_s   <= sync_1;
        end
    end

    // Third sample is the live rx_s at the decision point.
    assign maj  = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign dec  = (cnt == CNT_DEC);
    assign last = (cnt == CNT_LAST);

    always_ff @(posedge i_clk_aud or posedge i_aud_rst) begin
        if (i_aud_rst) begin
            state        <= ST_BREAK;
            cnt          <= '0;
            bit_idx      <= '0;
            samp         <= '0;
            shift        <= '0;
            o_midi_byte  <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            if (state == ST_START || state == ST_DATA || state == ST_STOP) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (cnt == CNT_S0) samp[0] <= rx_s;
                if (cnt == CNT_S1) samp[1] <= rx_s;
            end
            case (state)
                ST_BREAK: begin
                    if (rx_s) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (dec && maj) begin
                        state <= ST_IDLE;
                    end else if (last) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (dec) shift <= {maj, shift[7:1]};
                    if (last) begin
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    // Leave at the decision point so a following start bit is not missed.
                    if (dec) begin
                        if (maj) begin
                            o_midi_byte  <= shift;
                            o_byte_valid <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end
                end
                default: state <= ST_BREAK;
            endcase
        end
    end

    // Loaded during the strobe cycle; the strobe term covers that first cycle.
    always_ff @(posedge i_clk_aud or posedge i_aud_rst) begin
        if (i_aud_rst) begin
            act_cnt <= '0;
        end else if (o_byte_valid) begin
            act_cnt <= ACT_LOAD;
        end else if (act_cnt != '0) begin
            act_cnt <= act_cnt - 1'b1;
        end
    end

    assign o_activity = o_byte_valid | (act_cnt != '0);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Randomised bench for midi_uart_rx; expectations come from a frame-level model
// (latency formula, expected-event queue, activity window).
module tb_midi_uart_rx;
    import midi_uart_rx_pkg::*;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BAUD     = 31_250;
    localparam int ACT_CLKS = 500;
    localparam int BIT      = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF     = BIT / 2;
    localparam int LAT      = 9 * BIT + HALF + 5;
    localparam int FAST     = (BIT * 97 + 50) / 100;
    localparam int SLOW     = (BIT * 103 + 50) / 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       byte_valid;
    logic       frame_err;
    logic       activity;
    midi_byte_t midi_byte;

    midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ACT_CLKS(ACT_CLKS)) dut (
        .i_clk_aud   (clk),
        .i_aud_rst   (rst),
        .i_midi_rx   (rx),
        .o_byte_valid(byte_valid),
        .o_midi_byte (midi_byte),
        .o_frame_err (frame_err),
        .o_activity  (activity)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         when;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc        = 0;
    int         n_checks   = 0;
    int         n_errors   = 0;
    logic [7:0] model_byte = 8'h00;
    int         last_valid = 0;
    bit         have_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check_eq("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
            check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
            check_eq("rst_activity", {31'd0, activity}, 32'd0);
            check_eq("rst_midi_byte", {24'd0, midi_byte}, 32'd0);
            model_byte = 8'h00;
            have_valid = 1'b0;
        end else begin
            if (byte_valid || frame_err) begin
                check_eq("strobe_exclusive", {31'd0, byte_valid & frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("spurious_strobe", {31'd0, byte_valid | frame_err}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("strobe_kind", {31'd0, frame_err}, {31'd0, mon_e.err});
                    if (mon_e.when >= 0) check_eq("latency", cyc, mon_e.when);
                    if (!mon_e.err) begin
                        model_byte = mon_e.data;
                        last_valid = cyc;
                        have_valid = 1'b1;
                    end
                end
            end
            check_eq("midi_byte", {24'd0, midi_byte}, {24'd0, model_byte});
            check_eq("activity", {31'd0, activity},
                     {31'd0, have_valid && ((cyc - last_valid) < ACT_CLKS)});
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop, input bit expect_it);
        exp_t e;
        if (expect_it) begin
            e.err  = !stop;
            e.data = b;
            e.when = (per == BIT) ? cyc + LAT : -1;
            exp_q.push_back(e);
        end
        drive(1'b0, per);
        for (int i = 0; i < 8; i++) drive(b[i], per);
        drive(stop, per);
    endtask

    task automatic phase_done(input string name);
        check_eq({"pending_", name}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 20);

        send_frame(8'h90, BIT, 1'b1, 1'b1);
        drive(1'b1, 40);
        phase_done("single");

        send_frame(8'h90, BIT, 1'b1, 1'b1);
        send_frame(8'h3C, BIT, 1'b1, 1'b1);
        send_frame(8'h64, BIT, 1'b1, 1'b1);
        drive(1'b1, 40);
        phase_done("back_to_back");

        drive(1'b0, 1);
        drive(1'b1, 60);
        drive(1'b0, 12);
        drive(1'b1, 60);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, $urandom_range(HALF - 2, 1));
            drive(1'b1, $urandom_range(80, 40));
        end
        send_frame(8'hF8, BIT, 1'b1, 1'b1);
        drive(1'b1, 40);
        phase_done("glitch");

        send_frame(8'h55, BIT, 1'b0, 1'b1);
        drive(1'b0, 3 * BIT);
        drive(1'b1, 40);
        send_frame(8'h80, BIT, 1'b1, 1'b1);
        drive(1'b1, 40);
        phase_done("frame_err");

        fork
            send_frame(8'hFF, BIT, 1'b1, 1'b0);
            begin
                repeat (5 * BIT + 10) @(posedge clk);
                #2;
                rst = 1'b1;
                repeat (20) @(posedge clk);
                #2;
                rst = 1'b0;
            end
        join
        drive(1'b1, 40);
        send_frame(8'h3C, BIT, 1'b1, 1'b1);
        drive(1'b1, 40);
        phase_done("reset_mid_frame");

        for (int i = 0; i < 4; i++) send_frame(8'($urandom), FAST, 1'b1, 1'b1);
        drive(1'b1, 40);
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), SLOW, 1'b1, 1'b1);
        drive(1'b1, 40);
        phase_done("baud_tolerance");

        drive(1'b1, ACT_CLKS);
        send_frame(8'hB0, BIT, 1'b1, 1'b1);
        drive(1'b1, 100);
        send_frame(8'h7B, BIT, 1'b1, 1'b1);
        drive(1'b1, ACT_CLKS + 50);
        phase_done("activity");

        for (int i = 0; i < 10; i++) begin
            send_frame(8'($urandom), BIT, 1'b1, 1'b1);
            drive(1'b1, $urandom_range(40, 0));
        end
        drive(1'b1, 40);
        phase_done("random");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
